// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: shifts one parallel word out per frame as
// start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// One bit per CLK cycle. TX_OUT and BUSY are registered, and both are computed
// from the state being entered.
module uart_tx_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
  logic [CntW-1:0]       r_cnt, w_cnt_next;
  logic                  r_par_en, w_par_en_next;
  logic                  r_par_bit, w_par_bit_next;
  logic                  r_tx, w_tx_next;
  logic                  r_busy, w_busy_next;

  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

  // State, datapath and output registers; reset forces an idle-high line at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_cnt     <= w_cnt_next;
      r_par_en  <= w_par_en_next;
      r_par_bit <= w_par_bit_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
    end
  end

  // Next state, datapath updates, and the output values for the state being entered.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_cnt_next     = r_cnt;
    w_par_en_next  = r_par_en;
    w_par_bit_next = r_par_bit;
    w_tx_next      = 1'b1;
    w_busy_next    = 1'b1;

    case (r_state)
      StIdle: begin
        w_busy_next = 1'b0;
        if (DATA_VALID) begin
          // Latch the whole frame configuration here so later input changes cannot leak in.
          w_state_next   = StStart;
          w_shift_next   = P_DATA;
          w_par_en_next  = PAR_EN;
          w_par_bit_next = PAR_TYP ? ~^P_DATA : ^P_DATA;
          w_tx_next      = 1'b0;
          w_busy_next    = 1'b1;
        end
      end

      StStart: begin
        w_state_next = StData;
        w_cnt_next   = '0;
        w_tx_next    = r_shift[0];
      end

      StData: begin
        if (r_cnt == LastIdx) begin
          w_cnt_next = '0;
          if (r_par_en) begin
            w_state_next = StParity;
            w_tx_next    = r_par_bit;
          end else begin
            w_state_next = StStop;
          end
        end else begin
          // The current bit sits in r_shift[0], so the next one is r_shift[1].
          w_cnt_next   = r_cnt + CntW'(1);
          w_shift_next = r_shift >> 1;
          w_tx_next    = r_shift[1];
        end
      end

      StParity: begin
        w_state_next = StStop;
      end

      StStop: begin
        w_state_next = StIdle;
        w_busy_next  = 1'b0;
      end

      default: begin
        w_state_next = StIdle;
        w_busy_next  = 1'b0;
      end
    endcase
  end

endmodule
